// File: rtl/video_timing_pkg.sv
// Shared types and default timing for the PCW raster generator.
package video_timing_pkg;

    // Vertical timing modes; the encoding matches the i_mode pin.
    typedef enum logic {
        MODE_PAL  = 1'b0,
        MODE_NTSC = 1'b1
    } mode_e;

    // Vertical arithmetic is done at a fixed width wide enough for any sensible raster.
    localparam int VT_W = 16;
    typedef logic [VT_W-1:0] vt_val_t;

    // Raw vertical layout of one mode, in lines.
    typedef struct packed {
        vt_val_t fp;
        vt_val_t sync;
        vt_val_t bp;
        vt_val_t active;
    } v_mode_cfg_t;

    // Derived vertical boundaries of the mode in effect.
    typedef struct packed {
        vt_val_t va_end;
        vt_val_t vs_sta;
        vt_val_t vs_end;
        vt_val_t screen;
    } v_timing_t;

    localparam int DEF_H_FP           = 96;
    localparam int DEF_H_SYNC         = 64;
    localparam int DEF_H_BP           = 144;
    localparam int DEF_H_ACTIVE       = 720;
    localparam int DEF_V0_FP          = 26;
    localparam int DEF_V0_SYNC        = 4;
    localparam int DEF_V0_BP          = 26;
    localparam int DEF_V0_ACTIVE      = 256;
    localparam int DEF_V1_FP          = 30;
    localparam int DEF_V1_SYNC        = 4;
    localparam int DEF_V1_BP          = 26;
    localparam int DEF_V1_ACTIVE      = 200;
    localparam int DEF_PREFETCH       = 8;
    localparam int DEF_TIMER_LINES    = 52;
    localparam int DEF_TIMER_SYNC_OFS = 2;
    localparam int DEF_HW             = 11;
    localparam int DEF_VW             = 10;

    // Vertical layout is active, FP, sync, BP; returns the boundaries for the selected mode.
    function automatic v_timing_t calc_v_timing(input mode_e mode, input v_mode_cfg_t pal,
                                                input v_mode_cfg_t ntsc);
        v_mode_cfg_t c;
        v_timing_t   t;
        c        = (mode == MODE_NTSC) ? ntsc : pal;
        t.va_end = c.active;
        t.vs_sta = c.active + c.fp;
        t.vs_end = t.vs_sta + c.sync;
        t.screen = t.vs_end + c.bp;
        return t;
    endfunction

endpackage

// File: rtl/video_line_timer.sv
// Line-counted PCW timer: ticks every TIMER_LINES lines and is pulled into
// phase with the frame by a resync line shortly after vsync.
module video_line_timer #(
    parameter int TIMER_LINES = 52
) (
    input  logic clk,
    input  logic rst,
    input  logic pix_stb,
    input  logic line_end,
    input  logic resync,
    output logic tick
);

    localparam logic [5:0] RELOAD = 6'(TIMER_LINES - 1);

    logic [5:0] count;

    // Count lines down; a zero count or the resync line both reload and give a single one-strobe tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= RELOAD;
            tick  <= 1'b0;
        end else if (pix_stb) begin
            tick <= 1'b0;
            if (line_end) begin
                if ((count == 6'd0) || resync) begin
                    count <= RELOAD;
                    tick  <= 1'b1;
                end else begin
                    count <= count - 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters advanced by the pixel strobe, a shadow
// vertical mode swapped only at the frame wrap, and combinational decodes.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_FP           = DEF_H_FP,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BP           = DEF_H_BP,
    parameter int H_ACTIVE       = DEF_H_ACTIVE,
    parameter int V0_FP          = DEF_V0_FP,
    parameter int V0_SYNC        = DEF_V0_SYNC,
    parameter int V0_BP          = DEF_V0_BP,
    parameter int V0_ACTIVE      = DEF_V0_ACTIVE,
    parameter int V1_FP          = DEF_V1_FP,
    parameter int V1_SYNC        = DEF_V1_SYNC,
    parameter int V1_BP          = DEF_V1_BP,
    parameter int V1_ACTIVE      = DEF_V1_ACTIVE,
    parameter int PREFETCH       = DEF_PREFETCH,
    parameter int TIMER_LINES    = DEF_TIMER_LINES,
    parameter int TIMER_SYNC_OFS = DEF_TIMER_SYNC_OFS,
    parameter int HW             = DEF_HW,
    parameter int VW             = DEF_VW
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_stb,
    input  logic          i_mode,
    input  logic [VW-1:0] i_line_cmp,
    input  logic          i_line_irq_en,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_hblank,
    output logic          o_vblank,
    output logic          o_active,
    output logic          o_prefetch,
    output logic          o_linestart,
    output logic          o_screenstart,
    output logic          o_animate,
    output logic [HW-1:0] o_x,
    output logic [VW-2:0] o_y,
    output logic          o_mode,
    output logic [7:0]    o_frame,
    output logic          o_timer,
    output logic          o_line_irq
);

    // Horizontal layout is FP, sync, BP, active.
    localparam logic [HW-1:0] HS_STA = HW'(H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_FP + H_SYNC);
    localparam logic [HW-1:0] HA_STA = HW'(H_FP + H_SYNC + H_BP);
    localparam logic [HW-1:0] PF_STA = HW'(H_FP + H_SYNC + H_BP - PREFETCH);
    localparam logic [HW-1:0] H_LAST = HW'(H_FP + H_SYNC + H_BP + H_ACTIVE - 1);

    localparam v_mode_cfg_t PAL_CFG = '{fp: VT_W'(V0_FP), sync: VT_W'(V0_SYNC),
                                        bp: VT_W'(V0_BP), active: VT_W'(V0_ACTIVE)};
    localparam v_mode_cfg_t NTSC_CFG = '{fp: VT_W'(V1_FP), sync: VT_W'(V1_SYNC),
                                         bp: VT_W'(V1_BP), active: VT_W'(V1_ACTIVE)};

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    mode_e         mode_q;
    logic [7:0]    frame_q;
    logic          line_irq_q;
    v_timing_t     vt;
    vt_val_t       v_ext;
    logic          line_end;
    logic          frame_end;
    logic          resync;
    logic          hblank;
    logic          vblank;

    assign vt        = calc_v_timing(mode_q, PAL_CFG, NTSC_CFG);
    assign v_ext     = VT_W'(v_count);
    assign line_end  = (h_count == H_LAST);
    assign frame_end = line_end && (v_ext == vt.screen - VT_W'(1));
    assign resync    = (v_ext == vt.vs_end + VT_W'(TIMER_SYNC_OFS));

    // Raster counters; the shadow mode and frame count change only on the frame-wrap strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_count <= '0;
            v_count <= '0;
            mode_q  <= MODE_PAL;
            frame_q <= 8'd0;
        end else if (i_pix_stb) begin
            if (line_end) begin
                h_count <= '0;
                if (frame_end) begin
                    v_count <= '0;
                    mode_q  <= mode_e'(i_mode);
                    frame_q <= frame_q + 8'd1;
                end else begin
                    v_count <= v_count + VW'(1);
                end
            end else begin
                h_count <= h_count + HW'(1);
            end
        end
    end

    // Line-compare pulse: set at the end of the matching line, cleared by the next strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            line_irq_q <= 1'b0;
        end else if (i_pix_stb) begin
            line_irq_q <= line_end && i_line_irq_en && (v_count == i_line_cmp);
        end
    end

    video_line_timer #(
        .TIMER_LINES(TIMER_LINES)
    ) u_line_timer (
        .clk     (i_clk),
        .rst     (i_rst),
        .pix_stb (i_pix_stb),
        .line_end(line_end),
        .resync  (resync),
        .tick    (o_timer)
    );

    // Position decodes straight from the registered counters and the mode in effect.
    always_comb begin
        hblank        = (h_count < HA_STA);
        vblank        = (v_ext >= vt.va_end);
        o_hblank      = hblank;
        o_vblank      = vblank;
        o_hs          = !((h_count >= HS_STA) && (h_count < HS_END));
        o_vs          = !((v_ext >= vt.vs_sta) && (v_ext < vt.vs_end));
        o_active      = !hblank && !vblank;
        o_prefetch    = (h_count >= PF_STA) && !vblank;
        o_linestart   = (h_count == '0);
        o_screenstart = (h_count == '0) && (v_count == '0);
        o_animate     = line_end && (v_ext == vt.va_end - VT_W'(1));
        o_x           = hblank ? '0 : (h_count - HA_STA);
        o_y           = vblank ? (VW-1)'(vt.va_end - VT_W'(1)) : v_count[VW-2:0];
        o_mode        = mode_q;
        o_frame       = frame_q;
        o_line_irq    = line_irq_q;
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a shrunken raster:
// line = 24 px (hsync 4..6, active 12..23, prefetch from 10),
// mode 0 = 28 lines (active 20, vsync 23..24, resync line 26),
// mode 1 = 20 lines (active 14, vsync 16..17, resync line 19), timer every 8 lines.
module tb_video_timing_gen;

    localparam int HW = 11;
    localparam int VW = 10;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_pix_stb;
    logic          i_mode;
    logic [VW-1:0] i_line_cmp;
    logic          i_line_irq_en;
    logic          o_hs;
    logic          o_vs;
    logic          o_hblank;
    logic          o_vblank;
    logic          o_active;
    logic          o_prefetch;
    logic          o_linestart;
    logic          o_screenstart;
    logic          o_animate;
    logic [HW-1:0] o_x;
    logic [VW-2:0] o_y;
    logic          o_mode;
    logic [7:0]    o_frame;
    logic          o_timer;
    logic          o_line_irq;

    int checks = 0;
    int errors = 0;

    // Bench-side raster position (after the most recent strobe).
    int m_h;
    int m_v;
    int m_screen;

    logic [9:0] exp_tick_q[$];
    logic [9:0] exp_irq_q[$];
    logic [9:0] got_tick_q[$];
    logic [9:0] got_irq_q[$];
    bit         tick_prev;
    bit         irq_prev;
    bit         hold_done;

    video_timing_gen #(
        .H_FP(4), .H_SYNC(3), .H_BP(5), .H_ACTIVE(12),
        .V0_FP(3), .V0_SYNC(2), .V0_BP(3), .V0_ACTIVE(20),
        .V1_FP(2), .V1_SYNC(2), .V1_BP(2), .V1_ACTIVE(14),
        .PREFETCH(2), .TIMER_LINES(8), .TIMER_SYNC_OFS(1),
        .HW(HW), .VW(VW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pix_stb    (i_pix_stb),
        .i_mode       (i_mode),
        .i_line_cmp   (i_line_cmp),
        .i_line_irq_en(i_line_irq_en),
        .o_hs         (o_hs),
        .o_vs         (o_vs),
        .o_hblank     (o_hblank),
        .o_vblank     (o_vblank),
        .o_active     (o_active),
        .o_prefetch   (o_prefetch),
        .o_linestart  (o_linestart),
        .o_screenstart(o_screenstart),
        .o_animate    (o_animate),
        .o_x          (o_x),
        .o_y          (o_y),
        .o_mode       (o_mode),
        .o_frame      (o_frame),
        .o_timer      (o_timer),
        .o_line_irq   (o_line_irq)
    );

    // Clock
    always #5 i_clk = ~i_clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hs"}, o_hs, 1);
        check({tag, "_vs"}, o_vs, 1);
        check({tag, "_hblank"}, o_hblank, 1);
        check({tag, "_vblank"}, o_vblank, 0);
        check({tag, "_active"}, o_active, 0);
        check({tag, "_prefetch"}, o_prefetch, 0);
        check({tag, "_linestart"}, o_linestart, 1);
        check({tag, "_screenstart"}, o_screenstart, 1);
        check({tag, "_animate"}, o_animate, 0);
        check({tag, "_x"}, o_x, 0);
        check({tag, "_y"}, o_y, 0);
        check({tag, "_mode"}, o_mode, 0);
        check({tag, "_frame"}, o_frame, 0);
        check({tag, "_timer"}, o_timer, 0);
        check({tag, "_line_irq"}, o_line_irq, 0);
    endtask

    // One pixel strobe; sampled 1 ns after the edge. Records pulses by the line that ended.
    task automatic strobe();
        int pv;
        int ph;
        pv = m_v;
        ph = m_h;
        i_pix_stb = 1'b1;
        @(posedge i_clk);
        #1;
        i_pix_stb = 1'b0;
        if (m_h == 23) begin
            m_h = 0;
            if (m_v == m_screen - 1) begin
                m_v = 0;
                m_screen = i_mode ? 20 : 28;
            end else begin
                m_v = m_v + 1;
            end
        end else begin
            m_h = m_h + 1;
        end
        if (tick_prev) check("timer_width", o_timer, 0);
        if (irq_prev) check("irq_width", o_line_irq, 0);
        if (o_timer) begin
            got_tick_q.push_back(10'(pv));
            check("timer_eol_px", ph, 23);
        end
        if (o_line_irq) begin
            got_irq_q.push_back(10'(pv));
            check("irq_eol_px", ph, 23);
        end
        tick_prev = o_timer;
        irq_prev  = o_line_irq;
    endtask

    // With the strobe low everything, including the irq pulse, must hold.
    task automatic hold_check();
        hold_done = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        check("hold_irq", o_line_irq, 1);
        check("hold_linestart", o_linestart, 1);
        check("hold_y", o_y, 11);
        check("hold_frame", o_frame, 0);
    endtask

    task automatic run_frame(input int fi, input logic req_mode, input logic [9:0] cmp,
                             input logic en, input int e_lines, input int e_va,
                             input int e_vs, input logic e_mode);
        int n, lines, vs_first, vs_last, vb_first, y_bad, anim_cnt, anim_pos, act_px, mode_bad;
        int hs_first, hs_cnt, act_first, pref_first, pref_cnt, x_last, x_hb, y1_bad;
        logic [9:0] ga;
        logic [9:0] ea;
        string t;
        t = $sformatf("f%0d_", fi);
        n = 0; lines = 0; vs_first = -1; vs_last = -1; vb_first = -1; y_bad = 0;
        anim_cnt = 0; anim_pos = -1; act_px = 0; mode_bad = 0;
        hs_first = -1; hs_cnt = 0; act_first = -1; pref_first = -1; pref_cnt = 0;
        x_last = -1; x_hb = -1; y1_bad = 0;
        got_tick_q.delete();
        got_irq_q.delete();
        i_line_cmp    = cmp;
        i_line_irq_en = en;
        while (n < 1000) begin
            strobe();
            n++;
            if (n == 300) i_mode = req_mode;
            if (o_linestart) lines++;
            if (!o_vs) begin
                if (vs_first < 0) vs_first = m_v;
                vs_last = m_v;
            end
            if (o_vblank && vb_first < 0) vb_first = m_v;
            if (o_vblank && (o_y != 9'(e_va - 1))) y_bad++;
            if (o_animate) begin
                anim_cnt++;
                anim_pos = m_v * 100 + m_h;
            end
            if (o_active) act_px++;
            if (!o_screenstart && (o_mode != e_mode)) mode_bad++;
            if (m_v == 1) begin
                if (!o_hs) begin
                    if (hs_first < 0) hs_first = m_h;
                    hs_cnt++;
                end
                if (o_active && act_first < 0) act_first = m_h;
                if (o_prefetch) begin
                    if (pref_first < 0) pref_first = m_h;
                    pref_cnt++;
                end
                if (m_h == 23) x_last = o_x;
                if (m_h == 5) x_hb = o_x;
                if (o_y != 9'd1) y1_bad++;
            end
            if (o_line_irq && !hold_done) hold_check();
            if (o_screenstart) break;
        end
        check({t, "strobes"}, n, e_lines * 24);
        check({t, "lines"}, lines, e_lines);
        check({t, "vs_first"}, vs_first, e_vs);
        check({t, "vs_last"}, vs_last, e_vs + 1);
        check({t, "vblank_first"}, vb_first, e_va);
        check({t, "y_clamp_bad"}, y_bad, 0);
        check({t, "anim_cnt"}, anim_cnt, 1);
        check({t, "anim_pos"}, anim_pos, (e_va - 1) * 100 + 23);
        check({t, "active_px"}, act_px, e_va * 12);
        check({t, "mode_hold_bad"}, mode_bad, 0);
        check({t, "hs_first"}, hs_first, 4);
        check({t, "hs_cnt"}, hs_cnt, 3);
        check({t, "act_first"}, act_first, 12);
        check({t, "pref_first"}, pref_first, 10);
        check({t, "pref_cnt"}, pref_cnt, 14);
        check({t, "x_last"}, x_last, 11);
        check({t, "x_hblank"}, x_hb, 0);
        check({t, "y_line1_bad"}, y1_bad, 0);
        check({t, "tick_cnt"}, got_tick_q.size(), exp_tick_q.size());
        while (exp_tick_q.size() > 0 && got_tick_q.size() > 0) begin
            ga = got_tick_q.pop_front();
            ea = exp_tick_q.pop_front();
            check({t, "tick_line"}, ga, ea);
        end
        check({t, "irq_cnt"}, got_irq_q.size(), exp_irq_q.size());
        while (exp_irq_q.size() > 0 && got_irq_q.size() > 0) begin
            ga = got_irq_q.pop_front();
            ea = exp_irq_q.pop_front();
            check({t, "irq_line"}, ga, ea);
        end
        exp_tick_q.delete();
        exp_irq_q.delete();
    endtask

    initial begin
        int n;
        i_rst = 1'b1;
        i_pix_stb = 1'b0;
        i_mode = 1'b0;
        i_line_cmp = 10'd10;
        i_line_irq_en = 1'b1;
        m_h = 0;
        m_v = 0;
        m_screen = 28;
        tick_prev = 1'b0;
        irq_prev = 1'b0;
        hold_done = 1'b0;

        // Reset block
        repeat (3) @(posedge i_clk);
        #1;
        check_reset("rst_held");
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        check_reset("rst_rel");

        // Frame 0: mode 0, request mode 1 mid-frame
        exp_tick_q = '{10'd7, 10'd15, 10'd23, 10'd26};
        exp_irq_q  = '{10'd10};
        run_frame(0, 1'b1, 10'd10, 1'b1, 28, 20, 23, 1'b0);
        check("f0_mode_after", o_mode, 1);
        check("f0_frame_after", o_frame, 1);

        // Frame 1: mode 1, request mode 0 back
        exp_tick_q = '{10'd6, 10'd14, 10'd19};
        exp_irq_q  = '{10'd10};
        run_frame(1, 1'b0, 10'd10, 1'b1, 20, 14, 16, 1'b1);
        check("f1_mode_after", o_mode, 0);
        check("f1_frame_after", o_frame, 2);

        // Frame 2: mode 0, line interrupt disabled
        exp_tick_q = '{10'd7, 10'd15, 10'd23, 10'd26};
        run_frame(2, 1'b0, 10'd10, 1'b0, 28, 20, 23, 1'b0);
        check("f2_mode_after", o_mode, 0);
        check("f2_frame_after", o_frame, 3);

        // Frame 3: mode 0, compare beyond the screen, request mode 1
        exp_tick_q = '{10'd6, 10'd14, 10'd22, 10'd26};
        run_frame(3, 1'b1, 10'd400, 1'b1, 28, 20, 23, 1'b0);
        check("f3_mode_after", o_mode, 1);
        check("f3_frame_after", o_frame, 4);

        // Frame 4: mode 1, asynchronous reset at line 15, pixel 10
        i_line_cmp = 10'd10;
        n = 0;
        while (!(m_v == 15 && m_h == 10) && n < 1000) begin
            strobe();
            n++;
        end
        check("f4_reach", n, 15 * 24 + 10);
        check("f4_y_before", o_y, 13);
        @(negedge i_clk);
        i_pix_stb = 1'b1;
        #2;
        i_rst = 1'b1;
        #1;
        check_reset("rst_mid");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_pix_stb = 1'b0;
        #1;
        check_reset("rst_mid_rel");
        m_h = 0;
        m_v = 0;
        m_screen = 28;
        tick_prev = 1'b0;
        irq_prev = 1'b0;

        // Frame 5: counting and the timer restart from 0,0 in mode 0
        exp_tick_q = '{10'd7, 10'd15, 10'd23, 10'd26};
        exp_irq_q  = '{10'd10};
        run_frame(5, 1'b0, 10'd10, 1'b1, 28, 20, 23, 1'b0);
        check("f5_mode_after", o_mode, 0);
        check("f5_frame_after", o_frame, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
